// File: rtl/ap_ctrl_seq.sv
// Kernel control sequencer: launches N_CORES compute units, gathers their done pulses, drives ap_ctrl_hs outputs.
// Optional run-length counter enabled by defining AP_CTRL_PERF_EN; otherwise cycle_cnt_o is tied to zero.
module ap_ctrl_seq #(
    parameter int N_CORES   = 4,
    parameter int C_TIMEOUT = 0,
    parameter int C_TMO_W   = 32
) (
    input  logic               ap_clk,
    input  logic               ap_srst,
    input  logic               ap_start,
    input  logic               ap_start_pulse,
    output logic [N_CORES-1:0] core_start_o,
    input  logic [N_CORES-1:0] core_done_i,
    output logic               ap_done,
    output logic               ap_ready,
    output logic               ap_idle,
    output logic               timeout_o,
    output logic [31:0]        cycle_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam bit                 WDOG_EN  = (C_TIMEOUT != 0);
    localparam logic [C_TMO_W-1:0] TMO_LAST = WDOG_EN ? C_TMO_W'(C_TIMEOUT - 1) : '0;

    state_t             state_q;
    state_t             state_d;
    logic [N_CORES-1:0] done_mask_q;
    logic [N_CORES-1:0] done_seen;
    logic [C_TMO_W-1:0] wdog_q;
    logic               all_done;
    logic               wdog_expire;
    logic [N_CORES-1:0] core_start_d;
    logic               ap_done_d;
    logic               ap_idle_d;

    // ap_start only qualifies the handshake upstream; the launch comes from ap_start_pulse.
    logic start_unused;
    assign start_unused = ap_start;

    // In LAUNCH only this cycle's dones count; the mask is rebuilt from scratch each run.
    assign done_seen   = (state_q == ST_RUN) ? (done_mask_q | core_done_i) : core_done_i;
    assign all_done    = &done_seen;
    assign wdog_expire = WDOG_EN && (state_q == ST_RUN) && !all_done && (wdog_q == TMO_LAST);

    always_ff @(posedge ap_clk) begin
        if (ap_srst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (ap_start_pulse) state_d = ST_LAUNCH;
            ST_LAUNCH: state_d = all_done ? ST_DONE : ST_RUN;
            ST_RUN:    if (all_done || wdog_expire) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with the state.
    always_comb begin
        core_start_d = (state_d == ST_LAUNCH) ? '1 : '0;
        ap_done_d    = (state_d == ST_DONE);
        ap_idle_d    = (state_d == ST_IDLE);
    end

    always_ff @(posedge ap_clk) begin
        if (ap_srst) begin
            done_mask_q  <= '0;
            wdog_q       <= '0;
            core_start_o <= '0;
            ap_done      <= 1'b0;
            ap_ready     <= 1'b0;
            ap_idle      <= 1'b1;
            timeout_o    <= 1'b0;
        end else begin
            core_start_o <= core_start_d;
            ap_done      <= ap_done_d;
            ap_ready     <= ap_done_d;
            ap_idle      <= ap_idle_d;
            case (state_q)
                ST_LAUNCH: begin
                    done_mask_q <= core_done_i;
                    wdog_q      <= '0;
                    timeout_o   <= 1'b0;
                end
                ST_RUN: begin
                    done_mask_q <= done_seen;
                    if (wdog_q != '1) wdog_q <= wdog_q + C_TMO_W'(1);
                    if (wdog_expire) timeout_o <= 1'b1;
                end
                ST_DONE: begin
                    done_mask_q <= '0;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef AP_CTRL_PERF_EN
    logic [31:0] run_cnt_q;

    // Reported run length spans LAUNCH through DONE inclusive.
    always_ff @(posedge ap_clk) begin
        if (ap_srst) begin
            run_cnt_q   <= '0;
            cycle_cnt_o <= '0;
        end else begin
            case (state_q)
                ST_LAUNCH: run_cnt_q <= 32'd1;
                ST_RUN:    if (run_cnt_q != '1) run_cnt_q <= run_cnt_q + 32'd1;
                ST_DONE:   cycle_cnt_o <= (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + 32'd1;
                default: begin
                end
            endcase
        end
    end
`else
    assign cycle_cnt_o = '0;
`endif

endmodule
